pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural PC register and sequences instruction fetch for the 16-bit pipelined core. It arbitrates between sequential advance (PC+2), branch redirects from the resolution stage, hazard stalls, instruction-memory wait states and HALT. It drives the imem request handshake and the IF/ID write-enable and flush controls.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, byte increment for sequential fetch.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard unit: hold PC and IF/ID.
redirect  input  1  branch resolved taken; one-cycle pulse.
redirect_pc  input  16  target PC, valid with redirect.
halt_dec  input  1  HALT opcode (4'b1111) present in IF/ID.
imem_rdy  input  1  imem data valid for current request.
imem_req  output  1  fetch request.
imem_addr  output  16  fetch address; always equals pc.
pc  output  16  current PC.
pc_plus2  output  16  pc + PC_STEP, 16-bit wrap.
fetch_valid  output  1  IF/ID receives a valid instruction this cycle.
ifid_we  output  1  IF/ID write enable.
ifid_flush  output  1  zero IF/ID this cycle.
halted  output  1  core halted.

Behaviour:
- States: RUN, WAIT_MEM, HALT. Reset (async, rst_n=0): state=RUN, pc=RESET_PC, pend_valid=0; outputs imem_req=0 while rst_n=0, then 1 in the first cycle after release; fetch_valid=0, ifid_flush=0, halted=0.
- imem_req = (state != HALT). imem_addr = pc, combinational.
- Event priority per cycle: redirect > halt_dec > stall > memory.
- RUN:
  - redirect=1: pc<=redirect_pc; ifid_flush=1; fetch_valid=0; stay RUN. This holds even if imem_rdy=1.
  - else halt_dec=1: state<=HALT; pc held; fetch_valid=0.
  - else stall=1: pc held; ifid_we=0; fetch_valid=0. The memory result is discarded and refetched.
  - else imem_rdy=1: fetch_valid=1; ifid_we=1; pc<=pc_plus2.
  - else imem_rdy=0: state<=WAIT_MEM; pc held.
- WAIT_MEM: imem_req held high, imem_addr stable until imem_rdy.
  - redirect=1: latch pend_pc<=redirect_pc, pend_valid<=1; ifid_flush=1.
  - imem_rdy=1 with pend_valid=1 (or redirect this cycle): data dropped; fetch_valid=0; pc<=pending target (redirect_pc takes priority if both); pend_valid<=0; go to RUN.
  - imem_rdy=1, no pending redirect, stall=0: fetch_valid=1; pc<=pc_plus2; go to RUN.
  - imem_rdy=1, stall=1: data dropped; pc held; go to RUN.
  - halt_dec in WAIT_MEM: go to HALT once imem_rdy returns; data dropped.
- HALT: imem_req=0; fetch_valid=0; ifid_we=0; halted=1; pc frozen. redirect is ignored. Exit only via reset.
- ifid_we = fetch_valid | ifid_flush.
- pc_plus2 wraps: 16'hFFFE -> 16'h0000.
- Reset mid-WAIT_MEM: the request is abandoned and pend_valid is cleared.
- Bit 0 of redirect_pc is forced to 0 when loaded.

Optional Feature:
PC_SEQ_STATS_EN:
- When defined, adds outputs stall_cnt[15:0], redirect_cnt[15:0] and memwait_cnt[15:0], all cleared by reset.
  - stall_cnt counts cycles in which stall drops or holds a fetch.
  - redirect_cnt counts redirect pulses accepted outside HALT.
  - memwait_cnt counts cycles spent in WAIT_MEM.
  - All counters saturate at 16'hFFFF.
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Test Plan:
- Sequential fetch: reset, imem_rdy=1 constantly for 4 cycles -> pc goes 0000, 0002, 0004, 0006, 0008; fetch_valid=1 each cycle after reset.
- Wait state: at pc=0004, imem_rdy=0 for 3 cycles -> state WAIT_MEM, imem_addr=0004 held; rdy=1 -> fetch_valid=1 and pc=0006 on the next cycle.
- Redirect during wait: WAIT_MEM at pc=0010, redirect with redirect_pc=0x0040, then rdy 2 cycles later -> ifid_flush pulses once, fetch_valid=0 on the rdy cycle, pc=0040 afterwards.
- Redirect vs halt: redirect (target 0x0100) and halt_dec in the same cycle -> pc=0100, halted stays 0. A later halt_dec alone -> halted=1, imem_req=0, pc frozen for 10 cycles.
- Stall plus wrap: pc=FFFE with stall=1 for 2 cycles -> pc holds and ifid_we=0; release -> pc=0000.
- Asynchronous reset in WAIT_MEM with pending redirect -> pc=RESET_PC immediately, pend cleared, no fetch_valid after release until imem_rdy.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between pc_sequencer (master) and the surrounding core/imem (slave).
// With PC_SEQ_STATS_EN defined the bundle also carries the stall/redirect/memwait counters.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_dec;
  logic        imem_rdy;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_valid;
  logic        ifid_we;
  logic        ifid_flush;
  logic        halted;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] redirect_cnt;
  logic [15:0] memwait_cnt;

  modport master (
    input  stall, redirect, redirect_pc, halt_dec, imem_rdy,
    output imem_req, imem_addr, pc, pc_plus2, fetch_valid, ifid_we, ifid_flush, halted,
    output stall_cnt, redirect_cnt, memwait_cnt
  );
  modport slave (
    output stall, redirect, redirect_pc, halt_dec, imem_rdy,
    input  imem_req, imem_addr, pc, pc_plus2, fetch_valid, ifid_we, ifid_flush, halted,
    input  stall_cnt, redirect_cnt, memwait_cnt
  );
`else
  modport master (
    input  stall, redirect, redirect_pc, halt_dec, imem_rdy,
    output imem_req, imem_addr, pc, pc_plus2, fetch_valid, ifid_we, ifid_flush, halted
  );
  modport slave (
    output stall, redirect, redirect_pc, halt_dec, imem_rdy,
    input  imem_req, imem_addr, pc, pc_plus2, fetch_valid, ifid_we, ifid_flush, halted
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: sequential advance, redirects, stalls, imem wait states, HALT.
// Optional PC_SEQ_STATS_EN adds saturating stall/redirect/memwait counters.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {RUN, WAIT_MEM, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        halt_pend_q, halt_pend_d;
  logic        fetch_valid_c, ifid_flush_c;
  logic [15:0] redirect_tgt, pc_next_seq;

  assign redirect_tgt = {bus.redirect_pc[15:1], 1'b0};
  assign pc_next_seq  = pc_q + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 16'h0000;
      pend_valid_q <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  // A redirect or HALT seen while waiting on imem is remembered and acted on when the
  // outstanding request completes, so the address stays stable for the memory.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_valid_d  = pend_valid_q;
    halt_pend_d   = halt_pend_q;
    fetch_valid_c = 1'b0;
    ifid_flush_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.redirect) begin
          pc_d         = redirect_tgt;
          ifid_flush_c = 1'b1;
        end else if (bus.halt_dec) begin
          state_d = HALT;
        end else if (bus.stall) begin
          state_d = RUN;
        end else if (bus.imem_rdy) begin
          fetch_valid_c = 1'b1;
          pc_d          = pc_next_seq;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (bus.redirect) begin
          ifid_flush_c = 1'b1;
          pend_pc_d    = redirect_tgt;
          pend_valid_d = 1'b1;
          halt_pend_d  = 1'b0;
        end else if (bus.halt_dec) begin
          halt_pend_d = 1'b1;
        end
        if (bus.imem_rdy) begin
          pend_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (bus.redirect) begin
            pc_d    = redirect_tgt;
            state_d = RUN;
          end else if (pend_valid_q) begin
            pc_d    = pend_pc_q;
            state_d = RUN;
          end else if (bus.halt_dec || halt_pend_q) begin
            state_d = HALT;
          end else if (bus.stall) begin
            state_d = RUN;
          end else begin
            fetch_valid_c = 1'b1;
            pc_d          = pc_next_seq;
            state_d       = RUN;
          end
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Request and IF/ID controls are forced quiet while reset is held.
  assign bus.imem_req    = rst_n && (state_q != HALT);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus2    = pc_next_seq;
  assign bus.fetch_valid = rst_n && fetch_valid_c;
  assign bus.ifid_flush  = rst_n && ifid_flush_c;
  assign bus.ifid_we     = rst_n && (fetch_valid_c || ifid_flush_c);
  assign bus.halted      = (state_q == HALT);

`ifdef PC_SEQ_STATS_EN
  logic        stall_hit;
  logic [15:0] stall_cnt_q, redirect_cnt_q, memwait_cnt_q;

  assign stall_hit =
    ((state_q == RUN) && !bus.redirect && !bus.halt_dec && bus.stall) ||
    ((state_q == WAIT_MEM) && bus.imem_rdy && !bus.redirect && !pend_valid_q &&
     !bus.halt_dec && !halt_pend_q && bus.stall);

  // All three counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= 16'h0000;
      redirect_cnt_q <= 16'h0000;
      memwait_cnt_q  <= 16'h0000;
    end else begin
      if (stall_hit && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bus.redirect && (state_q != HALT) && (redirect_cnt_q != 16'hFFFF))
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if ((state_q == WAIT_MEM) && (memwait_cnt_q != 16'hFFFF))
        memwait_cnt_q <= memwait_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.memwait_cnt  = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total_cnt = 0;
  int   bad_cnt = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: where the core is (fetching, waiting, halted) and any remembered target.
  int  m_pc;
  bit  m_waiting, m_halted, m_has_target, m_halt_seen;
  int  m_target;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_waiting = 0; m_halted = 0; m_has_target = 0; m_halt_seen = 0; m_target = 0;
  endtask

  // One cycle: drive inputs after the falling edge, check outputs mid-cycle, then advance the model.
  task automatic apply_stimulus(input bit s, input bit r, input int rpc, input bit h, input bit rdy);
    bit fv, fl;
    int tgt, nxt_pc;
    bit nxt_wait, nxt_halt, nxt_has, nxt_hseen;
    int nxt_tgt;
    bus.stall = s; bus.redirect = r; bus.redirect_pc = 16'(rpc); bus.halt_dec = h; bus.imem_rdy = rdy;
    tgt = rpc & 32'hFFFE;
    fv = 0; fl = 0;
    nxt_pc = m_pc; nxt_wait = m_waiting; nxt_halt = m_halted;
    nxt_has = m_has_target; nxt_tgt = m_target; nxt_hseen = m_halt_seen;
    if (m_halted) begin
      // frozen until reset
    end else if (!m_waiting) begin
      if (r) begin fl = 1; nxt_pc = tgt; end
      else if (h) nxt_halt = 1;
      else if (s) begin end
      else if (rdy) begin fv = 1; nxt_pc = (m_pc + 2) % 65536; end
      else nxt_wait = 1;
    end else begin
      if (r) begin fl = 1; nxt_has = 1; nxt_tgt = tgt; nxt_hseen = 0; end
      else if (h) nxt_hseen = 1;
      if (rdy) begin
        nxt_wait = 0; nxt_has = 0; nxt_hseen = 0;
        if (r) nxt_pc = tgt;
        else if (m_has_target) nxt_pc = m_target;
        else if (h || m_halt_seen) nxt_halt = 1;
        else if (s) begin end
        else begin fv = 1; nxt_pc = (m_pc + 2) % 65536; end
      end
    end
    #2;
    check_output("pc", 32'(bus.pc), 32'(m_pc));
    check_output("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    check_output("pc_plus2", 32'(bus.pc_plus2), 32'((m_pc + 2) % 65536));
    check_output("imem_req", 32'(bus.imem_req), 32'(!m_halted));
    check_output("halted", 32'(bus.halted), 32'(m_halted));
    check_output("fetch_valid", 32'(bus.fetch_valid), 32'(fv));
    check_output("ifid_flush", 32'(bus.ifid_flush), 32'(fl));
    check_output("ifid_we", 32'(bus.ifid_we), 32'(fv | fl));
    @(posedge clk);
    m_pc = nxt_pc; m_waiting = nxt_wait; m_halted = nxt_halt;
    m_has_target = nxt_has; m_target = nxt_tgt; m_halt_seen = nxt_hseen;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, with imem_rdy high to show outputs stay quiet.
  task automatic async_reset();
    bus.imem_rdy = 1; bus.stall = 0; bus.redirect = 0; bus.halt_dec = 0;
    #3 rst_n = 0;
    #1;
    check_output("rst_pc", 32'(bus.pc), 32'h0000);
    check_output("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check_output("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
    check_output("rst_ifid_flush", 32'(bus.ifid_flush), 32'h0);
    check_output("rst_halted", 32'(bus.halted), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 16'h0; bus.halt_dec = 0; bus.imem_rdy = 0;
    model_reset();
    @(negedge clk);
    async_reset();

    $display("[TB] sequential fetch");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 1);
    check_output("seq_pc", 32'(bus.pc), 32'h0008);

    $display("[TB] wait states");
    async_reset();
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0);
    check_output("wait_addr", 32'(bus.imem_addr), 32'h0004);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("wait_pc", 32'(bus.pc), 32'h0006);

    $display("[TB] redirect during wait");
    apply_stimulus(0, 1, 16'h0010, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 16'h0041, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("redir_wait_pc", 32'(bus.pc), 32'h0040);

    $display("[TB] redirect vs halt");
    apply_stimulus(0, 1, 16'h0100, 1, 1);
    check_output("rvh_pc", 32'(bus.pc), 32'h0100);
    check_output("rvh_halted", 32'(bus.halted), 32'h0);
    apply_stimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)), 1'($urandom), 1'($urandom));
    check_output("halt_pc", 32'(bus.pc), 32'h0100);

    $display("[TB] stall and wrap");
    async_reset();
    apply_stimulus(0, 1, 16'hFFFE, 0, 1);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("wrap_hold", 32'(bus.pc), 32'hFFFE);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("wrap_pc", 32'(bus.pc), 32'h0000);

    $display("[TB] reset while waiting with pending redirect");
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 16'h0200, 0, 0);
    async_reset();
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("rst_pend_pc", 32'(bus.pc), 32'h0002);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if (i % 90 == 89) async_reset();
      apply_stimulus($urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 10,
                     int'($urandom_range(0, 65535)),
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 70);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
